// File: rtl/crc_serial_gen.sv
// Parametrised serial CRC generator/checker with valid/ready handshakes.
// Generate mode passes data through and appends the CRC MSB first; check mode flags a residue mismatch.
module crc_serial_gen #(
    parameter int unsigned      CRC_W   = 7,
    parameter logic [CRC_W-1:0] POLY    = 7'h09,
    parameter logic [CRC_W-1:0] SEED    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter logic [CRC_W-1:0] RESIDUE = '0
) (
    input  logic             RSTn,
    input  logic             CLK,
    input  logic             clear,
    input  logic             start,
    input  logic             chk_mode,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CRC_W-1:0] crc_value,
    output logic             crc_err
);

    localparam int unsigned CNT_W = $clog2(CRC_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CRC_W-1:0] crc_reg, crc_nxt, crc_acc;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mode, mode_nxt;
    logic             done_nxt, busy_nxt, crc_err_nxt;
    logic [CRC_W-1:0] crc_value_nxt;

    // One serial CRC step: shift left, fold in the polynomial when the feedback bit is set.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            crc_reg   <= SEED;
            cnt       <= '0;
            mode      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            crc_value <= '0;
            crc_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            crc_reg   <= crc_nxt;
            cnt       <= cnt_nxt;
            mode      <= mode_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            crc_value <= crc_value_nxt;
            crc_err   <= crc_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        crc_nxt       = crc_reg;
        cnt_nxt       = cnt;
        mode_nxt      = mode;
        done_nxt      = 1'b0;
        crc_value_nxt = crc_value;
        crc_err_nxt   = crc_err;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        out_bit       = 1'b0;
        out_last      = 1'b0;
        crc_acc       = crc_step(crc_reg, in_bit);

        case (state)
            IDLE: begin
                if (start) begin
                    crc_nxt   = SEED;
                    cnt_nxt   = '0;
                    mode_nxt  = chk_mode;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (!mode) begin
                    out_valid = in_valid;
                    out_bit   = in_bit;
                    in_ready  = out_ready;
                end else begin
                    in_ready  = 1'b1;
                end
                if (in_valid && in_ready) begin
                    crc_nxt = crc_acc;
                    if (in_last) begin
                        crc_value_nxt = crc_acc ^ XOR_OUT;
                        if (mode) begin
                            state_nxt   = IDLE;
                            done_nxt    = 1'b1;
                            crc_err_nxt = (crc_acc != RESIDUE);
                        end else begin
                            state_nxt   = SHIFT;
                            cnt_nxt     = CNT_W'(CRC_W - 1);
                            crc_err_nxt = 1'b0;
                        end
                    end
                end
            end
            SHIFT: begin
                // crc_reg shifts zero-filled, so the output XOR bit is picked by the remaining count.
                out_valid = 1'b1;
                out_bit   = crc_reg[CRC_W-1] ^ XOR_OUT[cnt];
                out_last  = (cnt == '0);
                if (out_ready) begin
                    crc_nxt = {crc_reg[CRC_W-2:0], 1'b0};
                    if (cnt == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort: no handshake completes in the clear cycle and results are left untouched.
        if (clear) begin
            state_nxt     = IDLE;
            crc_nxt       = SEED;
            cnt_nxt       = '0;
            done_nxt      = 1'b0;
            crc_value_nxt = crc_value;
            crc_err_nxt   = crc_err;
            in_ready      = 1'b0;
            out_valid     = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_crc_serial_gen.sv
// Bench for crc_serial_gen: a CRC-7 default instance and a CRC-16/CCITT instance share stimulus,
// outputs are compared against a polynomial long-division reference model.
module tb_crc_serial_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic clear = 1'b0, start7 = 1'b0, start16 = 1'b0, chk_mode = 1'b0;
    logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic sel = 1'b0;

    logic in_ready7, out_valid7, out_bit7, out_last7, busy7, done7, crc_err7;
    logic [6:0] crc_value7;
    logic in_ready16, out_valid16, out_bit16, out_last16, busy16, done16, crc_err16;
    logic [15:0] crc_value16;

    crc_serial_gen dut7 (
        .RSTn(rst_n), .CLK(clk), .clear(clear), .start(start7), .chk_mode(chk_mode),
        .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last), .in_ready(in_ready7),
        .out_valid(out_valid7), .out_bit(out_bit7), .out_last(out_last7), .out_ready(out_ready),
        .busy(busy7), .done(done7), .crc_value(crc_value7), .crc_err(crc_err7)
    );

    crc_serial_gen #(.CRC_W(16), .POLY(16'h1021), .SEED(16'hFFFF)) dut16 (
        .RSTn(rst_n), .CLK(clk), .clear(clear), .start(start16), .chk_mode(chk_mode),
        .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last), .in_ready(in_ready16),
        .out_valid(out_valid16), .out_bit(out_bit16), .out_last(out_last16), .out_ready(out_ready),
        .busy(busy16), .done(done16), .crc_value(crc_value16), .crc_err(crc_err16)
    );

    logic m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy, m_done, m_crc_err;
    logic [31:0] m_crc_value;
    assign m_in_ready  = sel ? in_ready16  : in_ready7;
    assign m_out_valid = sel ? out_valid16 : out_valid7;
    assign m_out_bit   = sel ? out_bit16   : out_bit7;
    assign m_out_last  = sel ? out_last16  : out_last7;
    assign m_busy      = sel ? busy16      : busy7;
    assign m_done      = sel ? done16      : done7;
    assign m_crc_err   = sel ? crc_err16   : crc_err7;
    assign m_crc_value = sel ? 32'(crc_value16) : 32'(crc_value7);

    int checks = 0;
    int failures = 0;
    bit msg[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Remainder of (msg * x^w) mod P by long division; a seed is added onto the leading w message bits.
    function automatic logic [31:0] ref_crc(input bit m_in[$], input int w,
                                            input logic [31:0] poly, input logic [31:0] seed);
        bit m[$];
        logic [31:0] r;
        int n;
        m = m_in;
        n = m_in.size();
        for (int i = 0; i < w; i++) m.push_back(1'b0);
        if (n >= w)
            for (int i = 0; i < w; i++) m[i] = m[i] ^ seed[w-1-i];
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                m[i] = 1'b0;
                for (int j = 0; j < w; j++) m[i+1+j] = m[i+1+j] ^ poly[w-1-j];
            end
        end
        r = '0;
        for (int j = 0; j < w; j++) r[w-1-j] = m[n+j];
        return r;
    endfunction

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) msg.push_back(b[i]);
    endtask

    task automatic add_bits(input logic [31:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) msg.push_back(v[i]);
    endtask

    function automatic int cur_w();
        return sel ? 16 : 7;
    endfunction

    function automatic logic [31:0] cur_crc(input bit m[$]);
        return sel ? ref_crc(m, 16, 32'h1021, 32'hFFFF) : ref_crc(m, 7, 32'h09, 32'h0);
    endfunction

    task automatic pulse_start(input string tag, input logic mode);
        @(negedge clk);
        if (sel) start16 = 1'b1; else start7 = 1'b1;
        chk_mode = mode;
        in_valid = 1'b1;
        in_bit   = msg[0];
        in_last  = (msg.size() == 1);
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready during start"}, 32'(m_in_ready), 32'd0);
        @(negedge clk);
        start7 = 1'b0;
        start16 = 1'b0;
        chk_mode = 1'b0;
    endtask

    // Generate-mode frame; stall_mode 0 = ready high, 1 = 1,0,0,1 pattern, 2 = random.
    task automatic run_gen(input string tag, input int stall_mode, input int gap_mode, input int clear_at);
        bit exp_q[$];
        bit got[$];
        logic [31:0] exp_crc;
        int n, w, idx, cyc, viol, last_cnt, last_pos, mism, dcnt;
        logic pend, prev_stall, prev_bit, prev_last, finished, aborted;
        n = msg.size();
        w = cur_w();
        exp_crc = cur_crc(msg);
        exp_q = msg;
        for (int j = w - 1; j >= 0; j--) exp_q.push_back(exp_crc[j]);
        idx = 0; cyc = 0; viol = 0; last_cnt = 0; last_pos = -1; mism = 0;
        pend = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
        finished = 1'b0; aborted = 1'b0;
        pulse_start(tag, 1'b0);
        while (!finished && !aborted && cyc < 600) begin
            if (clear_at >= 0 && got.size() == n + clear_at) begin
                clear = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
                @(negedge clk);
                clear = 1'b0;
                #1;
                check({tag, " busy after clear"}, 32'(m_busy), 32'd0);
                check({tag, " out_valid after clear"}, 32'(m_out_valid), 32'd0);
                dcnt = 0;
                for (int k = 0; k < 4; k++) begin
                    if (m_done) dcnt++;
                    @(negedge clk);
                end
                check({tag, " done after clear"}, 32'(dcnt), 32'd0);
                aborted = 1'b1;
            end else begin
                case (stall_mode)
                    1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                    2: out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b1;
                endcase
                if (!pend) begin
                    if (idx < n && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
                        in_valid = 1'b1; in_bit = msg[idx]; in_last = (idx == n - 1);
                    end else begin
                        in_valid = 1'b0; in_last = 1'b0; in_bit = 1'($urandom_range(0, 1));
                    end
                end
                #1;
                if (prev_stall && !(m_out_valid && m_out_bit == prev_bit && m_out_last == prev_last))
                    viol++;
                if (m_out_valid && out_ready) begin
                    got.push_back(m_out_bit);
                    if (m_out_last) begin last_cnt++; last_pos = got.size() - 1; end
                end
                prev_stall = m_out_valid && !out_ready;
                prev_bit = m_out_bit;
                prev_last = m_out_last;
                if (in_valid && m_in_ready) begin idx++; pend = 1'b0; end
                else pend = in_valid;
                @(negedge clk);
                cyc++;
                if (m_done) finished = 1'b1;
            end
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        if (!aborted) begin
            check({tag, " done reached"}, 32'(finished), 32'd1);
            check({tag, " output length"}, 32'(got.size()), 32'(exp_q.size()));
            for (int i = 0; i < got.size() && i < exp_q.size(); i++)
                if (got[i] != exp_q[i]) mism++;
            check({tag, " bit mismatches"}, 32'(mism), 32'd0);
            check({tag, " out_last count"}, 32'(last_cnt), 32'd1);
            check({tag, " out_last position"}, 32'(last_pos), 32'(n + w - 1));
            check({tag, " stall stability"}, 32'(viol), 32'd0);
            check({tag, " crc_value"}, m_crc_value, exp_crc);
            check({tag, " crc_err"}, 32'(m_crc_err), 32'd0);
            check({tag, " busy at done"}, 32'(m_busy), 32'd0);
            @(negedge clk);
            check({tag, " done one cycle"}, 32'(m_done), 32'd0);
        end
    endtask

    // Check-mode frame; msg already holds data followed by the received CRC bits.
    task automatic run_chk(input string tag);
        logic [31:0] rem;
        int n, idx, cyc, ov;
        logic pend, finished;
        n = msg.size();
        rem = cur_crc(msg);
        idx = 0; cyc = 0; ov = 0; pend = 1'b0; finished = 1'b0;
        pulse_start(tag, 1'b1);
        while (!finished && cyc < 600) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!pend) begin
                if (idx < n && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1; in_bit = msg[idx]; in_last = (idx == n - 1);
                end else begin
                    in_valid = 1'b0; in_last = 1'b0;
                end
            end
            #1;
            if (m_out_valid) ov++;
            if (in_valid && m_in_ready) begin idx++; pend = 1'b0; end
            else pend = in_valid;
            @(negedge clk);
            cyc++;
            if (m_done) finished = 1'b1;
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check({tag, " done reached"}, 32'(finished), 32'd1);
        check({tag, " no output in check mode"}, 32'(ov), 32'd0);
        check({tag, " crc_err"}, 32'(m_crc_err), 32'(rem != 32'd0));
        check({tag, " crc_value"}, m_crc_value, rem);
        check({tag, " busy at done"}, 32'(m_busy), 32'd0);
        @(negedge clk);
        check({tag, " done one cycle"}, 32'(m_done), 32'd0);
    endtask

    task automatic load_cmd0();
        msg.delete();
        add_byte(8'h40); for (int i = 0; i < 4; i++) add_byte(8'h00);
    endtask

    task automatic load_cmd8();
        msg.delete();
        add_byte(8'h48); add_byte(8'h00); add_byte(8'h00); add_byte(8'h01); add_byte(8'hAA);
    endtask

    initial begin
        logic [31:0] c;
        int len;
        #3;
        check("reset in_ready", 32'(in_ready7), 32'd0);
        check("reset out_valid", 32'(out_valid7), 32'd0);
        check("reset busy", 32'(busy7), 32'd0);
        check("reset done", 32'(done7), 32'd0);
        check("reset crc_value", 32'(crc_value7), 32'd0);
        check("reset crc_err", 32'(crc_err7), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        load_cmd0();
        run_gen("cmd0", 0, 0, -1);
        check("cmd0 crc constant", m_crc_value, 32'h4A);

        load_cmd8();
        run_gen("cmd8", 0, 0, -1);
        check("cmd8 crc constant", m_crc_value, 32'h43);

        load_cmd0(); add_bits(32'h4A, 7);
        run_chk("chk good");
        check("chk good err constant", 32'(m_crc_err), 32'd0);

        load_cmd0(); add_bits(32'h4A, 7);
        msg[5] = ~msg[5];
        run_chk("chk bad");
        check("chk bad err constant", 32'(m_crc_err), 32'd1);

        load_cmd0();
        run_gen("backpressure", 1, 0, -1);

        load_cmd0();
        run_gen("clear in shift", 0, 0, 3);
        load_cmd8();
        run_gen("after clear", 0, 0, -1);

        msg.delete(); msg.push_back(1'b1);
        run_gen("single bit", 2, 0, -1);

        for (int f = 0; f < 6; f++) begin
            msg.delete();
            len = $urandom_range(1, 48);
            for (int i = 0; i < len; i++) msg.push_back(1'($urandom_range(0, 1)));
            run_gen($sformatf("rand gen %0d", f), 2, 1, -1);
        end

        for (int f = 0; f < 4; f++) begin
            msg.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) msg.push_back(1'($urandom_range(0, 1)));
            c = cur_crc(msg);
            add_bits(c, 7);
            if (f % 2 == 1) begin
                len = $urandom_range(0, msg.size() - 1);
                msg[len] = ~msg[len];
            end
            run_chk($sformatf("rand chk %0d", f));
        end

        sel = 1'b1;
        msg.delete();
        for (int i = 0; i < 9; i++) add_byte(8'h31 + 8'(i));
        run_gen("crc16 123456789", 0, 0, -1);
        check("crc16 constant", m_crc_value, 32'h29B1);
        for (int f = 0; f < 2; f++) begin
            msg.delete();
            len = $urandom_range(16, 64);
            for (int i = 0; i < len; i++) msg.push_back(1'($urandom_range(0, 1)));
            run_gen($sformatf("crc16 rand %0d", f), 2, 1, -1);
        end

        sel = 1'b0;
        load_cmd8();
        run_gen("pre-reset", 0, 0, -1);
        pulse_start("reset mid accum", 1'b0);
        for (int i = 1; i < 6; i++) begin
            in_valid = 1'b1; in_bit = msg[i]; in_last = 1'b0; out_ready = 1'b1;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid reset busy", 32'(busy7), 32'd0);
        check("mid reset out_valid", 32'(out_valid7), 32'd0);
        check("mid reset in_ready", 32'(in_ready7), 32'd0);
        check("mid reset crc_value", 32'(crc_value7), 32'd0);
        check("mid reset crc_err", 32'(crc_err7), 32'd0);
        check("mid reset done", 32'(done7), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_serial_gen.md
Name: crc_serial_gen

Overview:
- Parametrised serial CRC generator/checker; the next generation of the fixed 7-bit serial CRC block.
- CRC width, polynomial, seed, output XOR and check residue are parameters; the current CRC-7 is the default configuration.
- Frame-based, with valid/ready handshakes on input and output.
- Generate mode: passes data bits through, then appends CRC_W CRC bits, MSB first.
- Check mode: consumes data plus received CRC bits and flags a mismatch.
- Sits between a serial command/data framer and the line driver or receiver.

Parameters:
- CRC_W, 7, CRC width in bits; legal range 3..32.
- POLY, 7'h09, generator polynomial without the implicit x^CRC_W term (default is x^7+x^3+1).
- SEED, 0, CRC register value at reset, at clear and at start.
- XOR_OUT, 0, value XORed onto the CRC before it is shifted out or reported.
- RESIDUE, 0, expected CRC register value after a good frame in check mode.

Ports:
- RSTn  input  1  asynchronous active-low reset.
- CLK  input  1  clock; all state updates on the rising edge.
- clear  input  1  synchronous abort; returns to IDLE.
- start  input  1  begin a frame; sampled only in IDLE.
- chk_mode  input  1  latched at start; 0 = generate, 1 = check.
- in_valid  input  1  in_bit is valid.
- in_bit  input  1  serial data bit, MSB first.
- in_last  input  1  marks the final input bit of the frame.
- in_ready  output  1  block accepts in_bit this cycle.
- out_valid  output  1  out_bit is valid.
- out_bit  output  1  serial output bit.
- out_last  output  1  marks the final output bit of the frame.
- out_ready  input  1  downstream accepts out_bit.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse at frame completion.
- crc_value  output  CRC_W  final CRC (crc_reg ^ XOR_OUT), held until the next done.
- crc_err  output  1  check-mode result; valid when done is 1, held afterwards.

Behaviour:
- Reset: RSTn is asynchronous and active-low; the clock is CLK. On reset:
  - state = IDLE, crc_reg = SEED, bit counter = 0.
  - done = 0, crc_err = 0, crc_value = 0.
  - out_valid = 0, in_ready = 0, busy = 0.
  - Reset mid-frame abandons the frame immediately; no done pulse.
- Priority: RSTn > clear > start / handshake activity.
- clear (any state):
  - Next state IDLE, crc_reg = SEED, counter = 0.
  - No done pulse; crc_value and crc_err keep their previous values.
- CRC update per accepted bit (in_valid & in_ready):
  - fb = in_bit ^ crc_reg[CRC_W-1].
  - crc_reg = {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 0).
  - Exactly one update per accepted bit; crc_reg holds when no bit is accepted.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start = 1: load crc_reg = SEED, latch chk_mode, go to ACCUM.
  - in_valid in the same cycle as start is not accepted.
- ACCUM, generate mode (pass-through, combinational):
  - out_valid = in_valid, out_bit = in_bit, in_ready = out_ready, out_last = 0.
  - Accepted bit with in_last = 1: go to SHIFT, counter = CRC_W-1, crc_reg updated with that bit.
- ACCUM, check mode:
  - in_ready = 1, out_valid = 0.
  - Accepted bit with in_last = 1: go to IDLE, pulse done next cycle.
  - crc_err = (updated crc_reg != RESIDUE); crc_value = updated crc_reg ^ XOR_OUT.
- SHIFT (generate mode only):
  - in_ready = 0, out_valid = 1.
  - out_bit = (crc_reg ^ XOR_OUT)[CRC_W-1]; out_last = (counter == 0).
  - On out_ready: crc_reg shifts left by one (zero fill) and counter decrements.
  - On out_ready with counter == 0: go to IDLE, done = 1 for one cycle.
  - crc_value = CRC captured at SHIFT entry; crc_err = 0.
- out_valid with out_ready low: out_bit and out_last stay stable (ACCUM follows the upstream in_valid/in_bit, which must hold).
- start is ignored while busy = 1.
- A single-bit frame (first accepted bit has in_last = 1) is legal.
- done and a new start may coincide; start is honoured because the state is IDLE.
- Latency:
  - ACCUM pass-through adds 0 cycles.
  - After the last data bit, SHIFT begins the next cycle.
  - SHIFT emits CRC_W bits in CRC_W cycles when out_ready is held high.

Test Plan:
- Defaults, generate mode, frame 0x40_00_00_00_00 (40 bits, out_ready = 1) -> 40 data bits passed through, then 7 bits 1001010 (0x4A); out_last on the 47th bit; done pulses; crc_value = 0x4A.
- Defaults, generate mode, frame 0x48_00_00_01_AA -> appended CRC 0x43; crc_value = 0x43.
- Check mode, frame 0x40_00_00_00_00 followed by 7 bits 0x4A, in_last on the 47th bit -> done, crc_err = 0; repeat with data bit 5 flipped -> crc_err = 1.
- Backpressure: out_ready toggled 1,0,0,1 during both ACCUM and SHIFT of the first frame -> identical 47-bit output sequence; out_bit stable while stalled; no bits dropped or duplicated.
- Abort cases:
  - clear in SHIFT after 3 CRC bits -> IDLE next cycle, no done, busy = 0; the next frame yields the correct CRC.
  - RSTn low mid-ACCUM -> all outputs at reset values immediately.
- CRC_W = 16, POLY = 16'h1021, SEED = 16'hFFFF, frame ASCII "123456789" -> crc_value = 16'h29B1, followed by 16 appended bits.
